// File: rtl/pipe_event_monitor.sv
// pipe_event_monitor: cycle counter plus NUM_EVT event counters with run limit, saturation and indexed read.
// Define PERF_SNAPSHOT_EN to add a shadow snapshot bank that the read port returns instead of live counts.
module pipe_event_monitor #(
  parameter int NUM_EVT   = 2,
  parameter int CNT_W     = 32,
  parameter int SEL_W     = 4,
  parameter int CYC_LIMIT = 30
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               snap_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT-1:0] ovf_o,
  output logic               running_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  // The cycle counter is stored at index NUM_EVT so the read index maps straight onto the bank.
  localparam int CYC    = NUM_EVT;
  localparam int NUM_RD = 1 << SEL_W;
  localparam logic [CNT_W-1:0] LIMIT_M1 = (CYC_LIMIT == 0) ? '0 : CNT_W'(CYC_LIMIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q   [NUM_EVT+1];
  logic [CNT_W-1:0]   cnt_d   [NUM_EVT+1];
  logic [CNT_W-1:0]   rd_src  [NUM_EVT+1];
  logic [CNT_W-1:0]   rd_bank [NUM_RD];
  logic [NUM_EVT-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]   rd_q;
  logic               running_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '{default: '0};
      ovf_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_d = RUN;
        RUN: begin
          if (cnt_q[CYC] != '1) cnt_d[CYC] = cnt_q[CYC] + 1'b1;
          for (int unsigned k = 0; k < NUM_EVT; k++) begin
            if (evt_i[k]) begin
              if (cnt_q[k] == '1) ovf_d[k] = 1'b1;
              else                cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
          // The limit edge still applies its own increments before freezing.
          if (CYC_LIMIT != 0 && cnt_q[CYC] == LIMIT_M1) state_d = DONE;
          else if (!start_i)                             state_d = IDLE;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shd_q [NUM_EVT+1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        shd_q <= '{default: '0};
    else if (clear_i) shd_q <= '{default: '0};
    else if (snap_i)  shd_q <= cnt_d;
  end

  assign rd_src = shd_q;
`else
  logic unused_snap;
  assign unused_snap = snap_i;
  assign rd_src      = cnt_q;
`endif

  always_comb begin
    rd_bank = '{default: '0};
    for (int unsigned k = 0; k <= NUM_EVT; k++) rd_bank[k] = rd_src[k];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '{default: '0};
      ovf_q     <= '0;
      rd_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_bank[sel_i];
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign rd_data_o = rd_q;
  assign ovf_o     = ovf_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Self-checking bench for pipe_event_monitor: scoreboard of per-edge outputs plus table-driven reads.
// A second instance (CNT_W=4, CYC_LIMIT=0) covers saturation and overflow.
module tb_pipe_event_monitor;
  localparam int NE  = 2;
  localparam int CW  = 32;
  localparam int SW  = 4;
  localparam int LIM = 30;

  logic          clk = 1'b0;
  logic          rst, start, clear, snap;
  logic [NE-1:0] evt;
  logic [SW-1:0] sel;
  logic [CW-1:0] rd;
  logic [NE-1:0] ovf;
  logic          running, done;

  logic          b_start, b_clear, b_evt, b_snap;
  logic [SW-1:0] b_sel;
  logic [3:0]    b_rd;
  logic          b_ovf, b_run, b_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_event_monitor #(.NUM_EVT(NE), .CNT_W(CW), .SEL_W(SW), .CYC_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .sel_i(sel), .snap_i(snap), .rd_data_o(rd), .ovf_o(ovf),
    .running_o(running), .done_o(done)
  );

  pipe_event_monitor #(.NUM_EVT(1), .CNT_W(4), .SEL_W(SW), .CYC_LIMIT(0)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .clear_i(b_clear), .evt_i(b_evt),
    .sel_i(b_sel), .snap_i(b_snap), .rd_data_o(b_rd), .ovf_o(b_ovf),
    .running_o(b_run), .done_o(b_done)
  );

  typedef struct {
    logic [CW-1:0] rd;
    logic [NE-1:0] ovf;
    logic          run;
    logic          dn;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [SW-1:0] sel;
    logic [CW-1:0] rd;
    logic          dn;
  } rdvec_t;
  rdvec_t tbl[5];

  // Reference model state: 0 idle, 1 run, 2 done; index NE holds the cycle count.
  int            m_st;
  logic [CW-1:0] m_cnt [NE+1];
  logic [CW-1:0] m_shd [NE+1];
  logic [NE-1:0] m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_ovf = '0;
    for (int k = 0; k <= NE; k++) begin
      m_cnt[k] = '0;
      m_shd[k] = '0;
    end
  endtask

  task automatic model_push();
    exp_t          e;
    int            idx;
    logic [CW-1:0] old_cyc;
    idx  = int'(sel);
    e.rd = '0;
`ifdef PERF_SNAPSHOT_EN
    if (idx <= NE) e.rd = m_shd[idx];
`else
    if (idx <= NE) e.rd = m_cnt[idx];
`endif
    if (clear) begin
      m_st = 0;
      m_ovf = '0;
      for (int k = 0; k <= NE; k++) m_cnt[k] = '0;
    end else if (m_st == 1) begin
      old_cyc = m_cnt[NE];
      if (m_cnt[NE] != {CW{1'b1}}) m_cnt[NE] = m_cnt[NE] + 1;
      for (int k = 0; k < NE; k++) begin
        if (evt[k]) begin
          if (m_cnt[k] == {CW{1'b1}}) m_ovf[k] = 1'b1;
          else                        m_cnt[k] = m_cnt[k] + 1;
        end
      end
      if (old_cyc == LIM - 1) m_st = 2;
      else if (!start)        m_st = 0;
    end else if (m_st == 0 && start) begin
      m_st = 1;
    end
    if (clear)     for (int k = 0; k <= NE; k++) m_shd[k] = '0;
    else if (snap) for (int k = 0; k <= NE; k++) m_shd[k] = m_cnt[k];
    e.ovf = m_ovf;
    e.run = (m_st == 1);
    e.dn  = (m_st == 2);
    sbq.push_back(e);
  endtask

  task automatic step(input logic st, input logic cl, input logic [NE-1:0] ev,
                      input logic [SW-1:0] sl, input logic sn);
    exp_t e;
    start = st; clear = cl; evt = ev; sel = sl; snap = sn;
    model_push();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_rd_data", rd, e.rd);
    chk("sb_ovf", ovf, e.ovf);
    chk("sb_running", running, e.run);
    chk("sb_done", done, e.dn);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] exp_snap_evt, exp_snap_cyc;
    rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0; evt = '0; sel = '0;
    b_start = 1'b0; b_clear = 1'b0; b_evt = 1'b0; b_snap = 1'b0; b_sel = '0;
    model_reset();

    tbl[0] = '{sel: 4'd0,  rd: 32'd10, dn: 1'b1};
    tbl[1] = '{sel: 4'd1,  rd: 32'd2,  dn: 1'b1};
    tbl[2] = '{sel: 4'd2,  rd: 32'd30, dn: 1'b1};
    tbl[3] = '{sel: 4'd3,  rd: 32'd0,  dn: 1'b1};
    tbl[4] = '{sel: 4'd15, rd: 32'd0,  dn: 1'b1};

    @(posedge clk);
    #1;
    chk("reset_rd", rd, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_running", running, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // Event pattern up to the limit; events on the IDLE->RUN edge must be ignored.
    step(1'b1, 1'b0, 2'b11, 4'd2, 1'b0);
    for (int c = 1; c <= 30; c++)
      step(1'b1, 1'b0, {(c == 5 || c == 29), ((c - 1) % 3 == 0)}, 4'd2, 1'b0);
    chk("limit_done", done, 1);
    chk("limit_running", running, 0);
    step(1'b1, 1'b0, 2'b11, 4'd2, 1'b0);
    chk("limit_cycle_count", rd, 30);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 2'b11, tbl[i].sel, 1'b0);
      chk("tbl_rd_data", rd, tbl[i].rd);
      chk("tbl_done", done, tbl[i].dn);
    end

    // clear and start together in DONE: IDLE, no count that edge, RUN on the next.
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0);
    chk("clr_done", done, 0);
    chk("clr_running", running, 0);
    step(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    chk("clr_cnt0_zero", rd, 0);
    chk("clr_then_run", running, 1);
    step(1'b1, 1'b0, 2'b00, 4'd2, 1'b0);
    chk("clr_edge_no_count", rd, 0);
    step(1'b1, 1'b0, 2'b00, 4'd2, 1'b0);
    chk("first_run_count", rd, 1);

    // Pause for four cycles mid-run, snapshot when the cycle count reaches 10.
    step(1'b0, 1'b1, 2'b00, 4'd0, 1'b0);
    step(1'b1, 1'b0, 2'b01, 4'd0, 1'b0);
    for (int i = 0; i < 40; i++)
      step(!(i >= 7 && i < 11), 1'b0, 2'b01, 4'd0, (m_st == 1 && m_cnt[NE] == 9));
    chk("pause_done", done, 1);
`ifdef PERF_SNAPSHOT_EN
    exp_snap_evt = 10;
    exp_snap_cyc = 10;
`else
    exp_snap_evt = 30;
    exp_snap_cyc = 30;
`endif
    step(1'b1, 1'b0, 2'b01, 4'd0, 1'b0);
    chk("pause_cnt0", rd, exp_snap_evt);
    step(1'b1, 1'b0, 2'b01, 4'd2, 1'b0);
    chk("pause_cycle", rd, exp_snap_cyc);

    // Asynchronous reset in the middle of RUN.
    step(1'b0, 1'b1, 2'b00, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'b11, 4'd2, 1'b0);
    chk("pre_reset_running", running, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_rd", rd, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_done", done, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 2'b00, 4'd2, 1'b0);
    chk("post_rst_cycle", rd, 0);

    // Saturation on the 4-bit instance with no cycle limit.
    b_start = 1'b1; b_evt = 1'b1; b_sel = 4'd0;
    step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      if (k == 15) chk("sat_ovf_before", b_ovf, 0);
      if (k == 16) chk("sat_ovf_at_16", b_ovf, 1);
    end
    chk("sat_cnt0", b_rd, 15);
    chk("sat_ovf_sticky", b_ovf, 1);
    chk("sat_still_running", b_run, 1);
    chk("sat_not_done", b_done, 0);
    b_clear = 1'b1; b_start = 1'b0;
    step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
    chk("sat_clr_ovf", b_ovf, 0);
    chk("sat_clr_idle", b_run, 0);
    b_clear = 1'b0;
    step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
    chk("sat_clr_cnt0", b_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
